// File: rtl/timer_counter.sv
// Programmable down-counting timer with CTRL/PRESET/COUNT registers and a masked interrupt.
// Define TIMER_PRESCALE_EN to divide the COUNT decrement rate by PRESCALE.
module timer_counter #(
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ADD,
    input  logic        WE,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADD_CTRL   = 2'b00;
    localparam logic [1:0] ADD_PRESET = 2'b01;
    localparam logic [1:0] ADD_COUNT  = 2'b10;

    generate
        if (PRESCALE < 1 || PRESCALE > 255) begin : g_prescale_range
            $error("timer_counter: PRESCALE must be in 1..255");
        end
    endgenerate

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_q, irq_d;
    logic        tick;

    logic ctrl_en, ctrl_auto, ctrl_im;
    assign ctrl_en   = ctrl_q[0];
    assign ctrl_auto = (ctrl_q[2:1] == 2'b01);
    assign ctrl_im   = ctrl_q[3];

`ifdef TIMER_PRESCALE_EN
    localparam logic [7:0] PSC_LAST = 8'(PRESCALE - 1);

    logic [7:0] psc_q, psc_d;

    // Prescaler only advances while counting; LOAD and CTRL writes restart it.
    always_comb begin
        psc_d = psc_q;
        tick  = (psc_q == PSC_LAST);
        if (WE && ADD == ADD_CTRL) begin
            psc_d = 8'd0;
        end else if (state_q == LOAD) begin
            psc_d = 8'd0;
        end else if (state_q == CNT && ctrl_en) begin
            psc_d = tick ? 8'd0 : psc_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            psc_q <= 8'd0;
        end else begin
            psc_q <= psc_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        irq_d    = irq_q;

        // A CTRL write restarts the timer and wins over any state-machine update.
        if (WE && ADD == ADD_CTRL) begin
            ctrl_d  = DataIn[3:0];
            state_d = IDLE;
            irq_d   = 1'b0;
        end else begin
            if (WE && ADD == ADD_PRESET) begin
                preset_d = DataIn;
            end
            case (state_q)
                IDLE: begin
                    if (ctrl_en) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    count_d = preset_q;
                    state_d = CNT;
                end
                CNT: begin
                    if (!ctrl_en) begin
                        state_d = IDLE;
                    end else if (tick) begin
                        if (count_q > 32'd1) begin
                            count_d = count_q - 32'd1;
                        end else begin
                            count_d = 32'd0;
                            irq_d   = 1'b1;
                            state_d = INT;
                        end
                    end
                end
                INT: begin
                    if (ctrl_auto) begin
                        irq_d   = 1'b0;
                        state_d = LOAD;
                    end else begin
                        ctrl_d[0] = 1'b0;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        DataOut = 32'd0;
        case (ADD)
            ADD_CTRL:   DataOut = {28'd0, ctrl_q};
            ADD_PRESET: DataOut = preset_q;
            ADD_COUNT:  DataOut = count_q;
            default:    DataOut = 32'd0;
        endcase
    end

    // Masking hides a pending interrupt without discarding it.
    assign IRQ = irq_q & ctrl_im;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: reset, one-shot, auto-reload, preset change, masking, reset mid-count.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [1:0]  ADD;
    logic        WE;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        IRQ;

    int n_chk;
    int n_fail;
    int c;

`ifdef TIMER_PRESCALE_EN
    localparam int PSC_EXPIRY = 10;
`else
    localparam int PSC_EXPIRY = 4;
`endif

    timer_counter #(.PRESCALE(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .ADD    (ADD),
        .WE     (WE),
        .DataIn (DataIn),
        .DataOut(DataOut),
        .IRQ    (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        ADD    = a;
        DataIn = d;
        WE     = 1'b1;
        tick();
        WE     = 1'b0;
        DataIn = 32'd0;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        ADD = a;
        #1;
        check(tag, DataOut, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {31'd0, IRQ}, {31'd0, exp});
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        WE     = 1'b0;
        ADD    = 2'b00;
        DataIn = 32'd0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk_irq("rst_irq", 1'b0);
        chk_reg("rst_ctrl", 2'b00, 32'd0);
        chk_reg("rst_preset", 2'b01, 32'd0);
        chk_reg("rst_count", 2'b10, 32'd0);

        // One-shot, PRESET=5, EN|IM
        wr(2'b01, 32'd5);
        chk_reg("unused_add", 2'b11, 32'd0);
        wr(2'b00, 32'h9);
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_reg($sformatf("os_count%0d", k), 2'b10, 32'(5 - k));
            chk_irq($sformatf("os_irq_pre%0d", k), 1'b0);
        end
        tick();
        chk_irq("os_irq_set", 1'b1);
        chk_reg("os_count0", 2'b10, 32'd0);
        tick();
        chk_reg("os_ctrl_en_clr", 2'b00, 32'h8);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk_irq($sformatf("os_irq_hold%0d", k), 1'b1);
        end
        wr(2'b00, 32'h0);
        chk_irq("os_irq_drop", 1'b0);

        // Auto-reload, PRESET=3: pulse every 5 cycles
        wr(2'b01, 32'd3);
        wr(2'b00, 32'hB);
        c = 0;
        while (c < 22) begin
            tick();
            c++;
            chk_irq($sformatf("ar_irq_c%0d", c), (c % 5) == 0);
            if (c == 7 || c == 12 || c == 22)
                chk_reg($sformatf("ar_reload_c%0d", c), 2'b10, 32'd3);
        end

        // PRESET change mid-count: current expiry unchanged, next period 12
        wr(2'b01, 32'd10);
        c++;
        chk_reg("pc_count_c23", 2'b10, 32'd2);
        while (c < 40) begin
            tick();
            c++;
            chk_irq($sformatf("pc_irq_c%0d", c), (c == 25) || (c == 37));
            if (c == 27)
                chk_reg("pc_count_c27", 2'b10, 32'd10);
        end
        wr(2'b00, 32'h0);

        // IM=0, PRESET=2: no IRQ, ignored COUNT write
        wr(2'b01, 32'd2);
        wr(2'b00, 32'h1);
        tick();
        chk_irq("m_irq_c1", 1'b0);
        tick();
        chk_reg("m_count_c2", 2'b10, 32'd2);
        wr(2'b10, 32'hFFFF);
        chk_reg("m_count_c3", 2'b10, 32'd1);
        chk_irq("m_irq_c3", 1'b0);
        for (int k = 4; k <= 6; k++) begin
            tick();
            chk_irq($sformatf("m_irq_c%0d", k), 1'b0);
        end
        chk_reg("m_count_end", 2'b10, 32'd0);
        chk_reg("m_ctrl_end", 2'b00, 32'h0);

        // Reset mid-count (COUNT=4), overriding a simultaneous CTRL write
        wr(2'b01, 32'd6);
        wr(2'b00, 32'h9);
        for (int k = 0; k < 4; k++) tick();
        chk_reg("r_count4", 2'b10, 32'd4);
        reset  = 1'b1;
        WE     = 1'b1;
        ADD    = 2'b00;
        DataIn = 32'hF;
        tick();
        reset  = 1'b0;
        WE     = 1'b0;
        DataIn = 32'd0;
        chk_irq("r_irq", 1'b0);
        chk_reg("r_ctrl", 2'b00, 32'd0);
        chk_reg("r_preset", 2'b01, 32'd0);
        chk_reg("r_count", 2'b10, 32'd0);

        // PRESET=2 expiry: 8 cycles after LOAD with prescaler, else 2
        wr(2'b01, 32'd2);
        wr(2'b00, 32'h9);
        for (int k = 1; k <= PSC_EXPIRY; k++) begin
            tick();
            chk_irq($sformatf("p_irq_c%0d", k), k >= PSC_EXPIRY);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
Programmable down-counting timer; the device that sits directly behind the system bridge at 0x7f00 (timer0) and 0x7f10 (timer1), one instance each. It consumes the bridge's register select, write-enable and write data, and returns read data. It raises IRQ to the CP0 interrupt inputs on count expiry. It has three word registers: CTRL (ADD=00), PRESET (ADD=01) and COUNT (ADD=10, read-only).

Parameters:
PRESCALE, 4, clock cycles per COUNT decrement when TIMER_PRESCALE_EN is defined; range 1..255; ignored otherwise.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
ADD  input  2  register select from bridge: 00 CTRL, 01 PRESET, 10 COUNT, 11 unused.
WE  input  1  write strobe from bridge (timer0we/timer1we).
DataIn  input  32  write data (bridge PrWD_O).
DataOut  output  32  read data for the selected register, combinational from ADD.
IRQ  output  1  interrupt request, registered.

Behaviour:
- Reset: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0. DataOut follows ADD (all-zero values); IRQ=0.
- CTRL fields:
  - bit0 EN.
  - bits2:1 MODE: 00 one-shot, 01 auto-reload; 10 and 11 behave as 00.
  - bit3 IM, interrupt mask (1 = enabled).
  - Bits 31:4 are not stored and read 0.
- Register writes:
  - WE with ADD=00: CTRL<=DataIn[3:0], state<=IDLE, irq_flag<=0. This overrides any state-machine update in the same cycle.
  - WE with ADD=01: PRESET<=DataIn. It has no effect on COUNT until the next LOAD.
  - WE with ADD=10 or 11: ignored.
- DataOut:
  - ADD=00 gives {28'b0, CTRL}.
  - ADD=01 gives PRESET.
  - ADD=10 gives COUNT.
  - ADD=11 gives 0.
- IRQ = irq_flag & IM.
- State machine (per edge, when there is no CTRL write):
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT:
    - If !EN, go to IDLE; COUNT holds.
    - Else if COUNT>1, COUNT<=COUNT-1.
    - Else (COUNT is 1 or 0): COUNT<=0, irq_flag<=1, go to INT.
  - INT:
    - MODE one-shot: EN<=0, go to IDLE, irq_flag held.
    - MODE auto-reload: irq_flag<=0, go to LOAD.
- Timing, with the enabling CTRL write at edge E0 and PRESET=N≥1:
  - LOAD at E1; COUNT=N after E2; COUNT=1 after E2+N-1; COUNT=0 and IRQ=1 after E2+N.
  - Auto-reload: IRQ is high for exactly 1 cycle, and the period is N+2 cycles.
  - One-shot: IRQ stays high until the next CTRL write or reset.
- PRESET=0 behaves as PRESET=1: INT is entered one edge after LOAD.
- No wrap-around: COUNT never decrements below 0.
- Reset asserted mid-count returns everything to reset values on that edge and overrides WE.
- Clearing IM masks IRQ but leaves irq_flag intact; setting IM again re-exposes it. Note that a CTRL write also clears irq_flag, so re-enabling IM through a CTRL write exposes nothing already pending.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - An 8-bit prescaler counter runs only in CNT. A decrement or expiry check happens only when the prescaler reaches PRESCALE-1, after which it returns to 0.
  - The prescaler is cleared by reset, by a CTRL write, and on entry to LOAD.
  - Expiry after LOAD takes N*PRESCALE cycles.
- Undefined: the prescaler logic is absent, and CNT acts on every edge as specified above.

Test Plan:
- Reset, then read ADD=00/01/10 -> DataOut=0 for each; IRQ=0.
- Write PRESET=5, then CTRL=0x9 (EN, one-shot, IM) at E0 -> COUNT reads 5,4,3,2,1 over E2..E6; IRQ=1 after E7; CTRL reads 0x8; IRQ stays 1 for 20 further cycles; writing CTRL=0 drops IRQ the next cycle.
- Write PRESET=3, then CTRL=0xB (auto-reload, IM) -> IRQ pulses 1 cycle wide every 5 cycles; three pulses observed; COUNT reloads to 3 after each pulse.
- During counting (COUNT=3), write PRESET=10 -> current expiry is unchanged; in auto-reload, the following period is 12 cycles.
- Write CTRL=0x1 (IM=0) with PRESET=2 -> IRQ stays 0 throughout while COUNT reaches 0 and EN clears; WE with ADD=10 and data 0xFFFF is ignored (COUNT unchanged).
- Assert reset with COUNT=4 mid-count -> all registers read 0 and IRQ=0 next cycle; with TIMER_PRESCALE_EN and PRESCALE=4, PRESET=2 gives expiry 8 cycles after LOAD.
